// File: rtl/spram_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: FSM states and requester ids.
package spram_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  function automatic req_id_t other_req(input req_id_t r);
    return (r == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Two-requester RAM access bus; master = requester side, slave = arbiter side.
interface spram_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);

  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rvalid0, rdata0,
    input  ack1, rvalid1, rdata1
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rvalid0, rdata0,
    output ack1, rvalid1, rdata1
  );

endinterface

// File: rtl/spram_arbiter_spram.sv
// Single-port RAM with registered output, write-first on a same-cycle write.
module spram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and q have no reset so this maps onto a RAM macro;
  // the arbiter's zero-fill gives the contents a defined value instead.
  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
      q            <= data;
    end else begin
      q <= mem[address];
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Owns one spram: zero-fills it after reset, then shares it between two
// requesters with per-cycle arbitration and a bounded burst under contention.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  parameter int INIT_CLEAR = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            init_done,
  spram_arbiter_if.slave  bus
);

  localparam int              BW          = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0]   BURST_LIM   = BW'(BURST_MAX);
  localparam state_t          RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_ARB;

  state_t                  state, state_next;
  logic [ADDR_WIDTH:0]     fill_addr, fill_next;
  req_id_t                 last_grant;
  logic [BW-1:0]           burst_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;

  logic                    grant;
  req_id_t                 winner;
  logic                    win_we;
  logic                    ram_wren;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_data;
  logic [DATA_WIDTH-1:0]   ram_q;
  logic                    rvalid0_q, rvalid1_q;

  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    fill_next  = fill_addr;
    grant      = 1'b0;
    winner     = last_grant;
    win_we     = 1'b0;
    ram_wren   = 1'b0;
    ram_addr   = addr_q;
    ram_data   = '0;

    unique case (state)
      ST_INIT: begin
        ram_wren  = 1'b1;
        ram_addr  = fill_addr[ADDR_WIDTH-1:0];
        fill_next = fill_addr + (ADDR_WIDTH + 1)'(1);
        if (fill_next[ADDR_WIDTH]) state_next = ST_ARB;
      end
      ST_ARB: begin
        if (init_done && (bus.req0 || bus.req1)) begin
          grant = 1'b1;
          // The burst limit only matters when both sides are waiting.
          if (bus.req0 && bus.req1)
            winner = (burst_cnt < BURST_LIM) ? last_grant : other_req(last_grant);
          else
            winner = bus.req1 ? REQ1 : REQ0;

          if (winner == REQ1) begin
            win_we   = bus.we1;
            ram_addr = bus.addr1;
            ram_data = bus.wdata1;
          end else begin
            win_we   = bus.we0;
            ram_addr = bus.addr0;
            ram_data = bus.wdata0;
          end
          ram_wren = win_we;
        end
      end
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_addr  <= '0;
      last_grant <= REQ1;
      burst_cnt  <= BURST_LIM;
      addr_q     <= '0;
      init_done  <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      fill_addr <= fill_next;
      addr_q    <= ram_addr;
      init_done <= (state_next == ST_ARB);
      rvalid0_q <= grant && (winner == REQ0) && !win_we;
      rvalid1_q <= grant && (winner == REQ1) && !win_we;
      if (grant) begin
        if (winner == last_grant) begin
          if (burst_cnt != BURST_LIM) burst_cnt <= burst_cnt + BW'(1);
        end else begin
          burst_cnt  <= BW'(1);
          last_grant <= winner;
        end
      end
    end
  end

  spram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_spram (
    .clock   (clock),
    .wren    (ram_wren),
    .address (ram_addr),
    .data    (ram_data),
    .q       (ram_q)
  );

  assign bus.ack0    = grant && (winner == REQ0);
  assign bus.ack1    = grant && (winner == REQ1);
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = ram_q;
  assign bus.rdata1  = ram_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: a memory/grant-history model checked every
// cycle, plus hand-computed expectations for fill length, bursts and resets.
module tb_spram_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int BM    = 4;
  localparam int DEPTH = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic init_done;

  spram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BM),
    .INIT_CLEAR (1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory image, edges since reset, grant history, pending read.
  logic [DW-1:0] mem_m [DEPTH];
  int            cyc = 0;
  bit            hist[$];
  bit            pend_rv0 = 1'b0, pend_rv1 = 1'b0;
  logic [DW-1:0] pend_data;
  bit            s_grant = 1'b0, s_win, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  // Length of the current run of grants to one requester; an empty history
  // behaves as if req1 had just used a full burst.
  function automatic void last_run(output bit last, output int run);
    if (hist.size() == 0) begin
      last = 1'b1;
      run  = BM;
    end else begin
      last = hist[hist.size()-1];
      run  = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != last) break;
        run++;
      end
    end
  endfunction

  always @(negedge clock) begin
    bit arb, last, win;
    int run;
    if (!reset_n) begin
      s_grant = 1'b0;
      check("rst_init_done", init_done, 0);
      check("rst_ack0", bus.ack0, 0);
      check("rst_ack1", bus.ack1, 0);
      check("rst_rvalid0", bus.rvalid0, 0);
      check("rst_rvalid1", bus.rvalid1, 0);
    end else begin
      arb     = (cyc >= DEPTH);
      s_grant = arb && (bus.req0 || bus.req1);
      if (bus.req0 && bus.req1) begin
        last_run(last, run);
        win = (run < BM) ? last : !last;
      end else begin
        win = bus.req1;
      end
      s_win   = win;
      s_we    = win ? bus.we1 : bus.we0;
      s_addr  = win ? bus.addr1 : bus.addr0;
      s_wdata = win ? bus.wdata1 : bus.wdata0;
      check("init_done", init_done, arb);
      check("ack0", bus.ack0, s_grant && !win);
      check("ack1", bus.ack1, s_grant && win);
      check("rvalid0", bus.rvalid0, pend_rv0);
      check("rvalid1", bus.rvalid1, pend_rv1);
      if (pend_rv0) check("rdata0", bus.rdata0, pend_data);
      if (pend_rv1) check("rdata1", bus.rdata1, pend_data);
    end
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      cyc = 0;
      hist.delete();
      pend_rv0 = 1'b0;
      pend_rv1 = 1'b0;
    end else if (cyc < DEPTH) begin
      mem_m[cyc] = '0;
      cyc++;
      pend_rv0 = 1'b0;
      pend_rv1 = 1'b0;
    end else begin
      pend_rv0 = s_grant && !s_win && !s_we;
      pend_rv1 = s_grant && s_win && !s_we;
      if (s_grant) begin
        if (s_we) mem_m[s_addr] = s_wdata;
        else      pend_data = mem_m[s_addr];
        hist.push_back(s_win);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.we0  = 1'b0;
    bus.we1  = 1'b0;
  endtask

  task automatic drive(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 40) begin
      step();
      n++;
    end
  endtask

  // One access; returns just after the edge that performs it.
  task automatic access(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    drive(p, we, a, d);
    #1;
    while (!(p ? bus.ack1 : bus.ack0) && n < 40) begin
      step();
      n++;
    end
    check("ack_within_bound", (n < 40) ? 1 : 0, 1);
    step();
    if (p) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int            n;
    int            cnt;
    logic [11:0]   pat;

    idle();
    bus.addr0 = '0; bus.wdata0 = '0;
    bus.addr1 = '0; bus.wdata1 = '0;

    // Request held through reset and fill: acked in the first arbitration cycle.
    drive(0, 0, 4'd2, 8'h00);
    reset_n = 1'b0;
    step();
    check("lit_reset_init_done", init_done, 0);
    check("lit_reset_ack0", bus.ack0, 0);
    step();
    reset_n = 1'b1;
    n = 0;
    while (!bus.ack0 && n < 40) begin
      step();
      n++;
    end
    check("lit_first_ack_cycle", n, 16);
    check("lit_init_done_at_ack", init_done, 1);
    step();
    idle();
    check("lit_init_read_rvalid0", bus.rvalid0, 1);
    check("lit_init_read_rdata0", bus.rdata0, 8'h00);

    // Every word reads back zero after the fill.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, AW'(i), 8'h00);
      step();
    end
    idle();
    check("lit_fill_last_rvalid0", bus.rvalid0, 1);
    check("lit_fill_last_rdata0", bus.rdata0, 8'h00);

    // Write then read back on req0.
    access(0, 1, 4'd3, 8'hA5);
    check("lit_write_no_rvalid0", bus.rvalid0, 0);
    access(0, 0, 4'd3, 8'h00);
    check("lit_rd3_rvalid0", bus.rvalid0, 1);
    check("lit_rd3_rdata0", bus.rdata0, 8'hA5);
    check("lit_rd3_rvalid1", bus.rvalid1, 0);

    // Back-to-back write then read of the same word on req1.
    drive(1, 1, 4'd9, 8'h3C);
    step();
    drive(1, 0, 4'd9, 8'h00);
    step();
    idle();
    check("lit_raw_rvalid1", bus.rvalid1, 1);
    check("lit_raw_rdata1", bus.rdata1, 8'h3C);

    // Contention from a fresh reset: bursts of four alternate starting with req0.
    do_reset();
    wait_init(n);
    check("lit_refill_cycles", n, 16);
    drive(0, 0, 4'd3, 8'h00);
    drive(1, 0, 4'd9, 8'h00);
    #1;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      pat = {pat[10:0], bus.ack1};
      check("one_ack_per_cycle", bus.ack0 && bus.ack1, 0);
      step();
    end
    check("lit_grant_pattern", pat, 12'b0000_1111_0000);
    idle();

    // A lone requester is never throttled by the burst limit.
    drive(1, 0, 4'd5, 8'h00);
    #1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cnt += bus.ack1 ? 1 : 0;
      step();
    end
    check("lit_solo_ack1_count", cnt, 10);
    idle();
    step();

    // Reset while the fill is presenting address 7 restarts the full fill.
    do_reset();
    repeat (7) step();
    reset_n = 1'b0;
    step();
    check("lit_midfill_init_done", init_done, 0);
    step();
    reset_n = 1'b1;
    wait_init(n);
    check("lit_midfill_restart_cycles", n, 16);

    // Reset landing after a read ack discards the pending rvalid.
    drive(0, 0, 4'd3, 8'h00);
    #1;
    check("lit_preread_ack0", bus.ack0, 1);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("lit_discard_rvalid0", bus.rvalid0, 0);
    idle();
    step();
    reset_n = 1'b1;
    wait_init(n);
    check("lit_postread_refill_cycles", n, 16);
    check("lit_postread_rvalid0", bus.rvalid0, 0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
